ula_op_sequencer: RTL
=====================

Name: ula_op_sequencer

Overview:
Sequential front-end for the 4-bit ULA datapath on the DE10-class board. It debounces the two push-buttons, holds a registered operation code, and latches operands from the switches. On an execute command it drives the combinational ULA, waits a fixed settle time, then captures the 8-bit result and flags into output registers. Display and LED logic read these registers instead of live switches, so the shown result stays stable while the switches change.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a key must be stable before a press is accepted (10 ms at 50 MHz)
SETTLE_CYCLES, 4, cycles the ULA inputs are held before the result is captured (≥1)
NUM_OPS, 7, number of valid op codes (0..NUM_OPS-1); code 7 is never issued

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_n  in  2  raw push-buttons, active-low; [1]=next-op, [0]=execute
sw  in  10  [3:0]=A, [7:4]=B, [8]=carry-in, [9]=chain mode
alu_a  out  4  operand A to ULA
alu_b  out  4  operand B to ULA
alu_cin  out  1  carry-in to ULA
alu_sel  out  3  op code to ULA (0 sum, 1 sub, 2 and, 3 or, 4 mult, 5 xor, 6 div)
alu_result  in  8  ULA result
alu_cout  in  1  ULA carry-out (sum)
alu_neg  in  1  ULA subtract-negative indicator
op_q  out  3  currently selected op (drives the op display)
result_q  out  8  captured result
flag_zero_q  out  1  captured result == 0
flag_err_q  out  1  captured div-by-zero or negative subtract
flag_cout_q  out  1  captured carry-out, op 0 only
busy  out  1  high in LOAD/SETTLE/CAPTURE
done  out  1  one-cycle pulse on the cycle result_q updates

Behaviour:
- Reset (async, rst_n low): state IDLE, op_q=0, result_q=0, all flags 0, busy=0, done=0, alu_a/b/cin=0, alu_sel=0, debounce counters cleared, key state "released". Reset mid-operation aborts with no capture.
- Key input: 2-FF synchronizer per key, then a stability counter. The debounced level changes only after DEBOUNCE_CYCLES identical samples. A press event is a one-cycle pulse on the debounced falling edge of key_n. Holding a key yields exactly one event.
- next-op event: op_q <= (op_q==NUM_OPS-1) ? 0 : op_q+1. This is accepted only in IDLE and ignored while busy.
- FSM states: IDLE, LOAD, SETTLE, CAPTURE.
  - IDLE: on an execute event go to LOAD. If execute and next-op arrive in the same cycle, execute wins and next-op is dropped.
  - LOAD, 1 cycle: latch alu_b=sw[7:4], alu_cin=sw[8], alu_sel=op_q. Set alu_a = sw[9] ? result_q[3:0] : sw[3:0] (chain mode). Load the settle counter with SETTLE_CYCLES-1.
  - SETTLE: decrement the counter; at 0 go to CAPTURE. Operands stay constant throughout.
  - CAPTURE, 1 cycle: result_q <= alu_result, except div with alu_b==0, which forces result_q=0.
    - flag_zero_q <= (captured value==0).
    - flag_err_q <= (sel==6 && alu_b==0) || (sel==1 && alu_neg).
    - flag_cout_q <= (sel==0) && alu_cout.
    - done=1, then return to IDLE.
- Execute events arriving while busy are dropped, not queued.
- Latency: execute event to done = SETTLE_CYCLES+2 cycles.
- Switch changes after LOAD have no effect until the next execute.

Decomposition:
- Shared package holds: op code localparams (OP_SUM..OP_DIV, OP_NONE=7), FSM state encoding, DEBOUNCE_CYCLES default.
- One sub-module, key_debounce (sync + stability counter + press pulse), instantiated twice.
- FSM, op register and capture registers stay in the top module.

Test Plan:
1. Reset then idle: rst_n low→high; 0 key activity → op_q=0, result_q=0, all flags 0, busy=0 indefinitely.
2. Sum with carry: DEBOUNCE_CYCLES=4, sw A=9, B=8, cin=1, op 0, execute press → done after SETTLE_CYCLES+2 cycles; model returns 18 → result_q=18, flag_cout_q=1, flag_err_q=0.
3. Op cycling and wrap: 7 next-op presses from op 0 → op_q walks 1..6 then 0. Key bounce of 2-cycle glitches → no extra steps.
4. Div by zero: op 6, B=0, A=5 → result_q=0, flag_err_q=1, flag_zero_q=1.
5. Chain mode: sum 3+4 gives 7; then sw[9]=1, sw[3:0]=15, B=2, execute → alu_a observed =7 during SETTLE, result_q=9.
6. Reset mid-operation and busy rejection:
   - Execute, then a second execute and a next-op during SETTLE → both dropped, single done.
   - rst_n low during SETTLE → result_q stays 0, no done pulse.

Source files
------------

// File: rtl/ula_op_sequencer_pkg.sv
// Shared op codes, FSM state encoding and board-level timing defaults for the ULA sequencer.
package ula_op_sequencer_pkg;

    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_MULT = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_NONE = 3'd7;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ula_op_sequencer_key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter, one-cycle pulse on debounced press.
module key_debounce
    import ula_op_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        cnt_d   = cnt_q;
        level_d = level_q;
        // Any sample matching the current level restarts the stability window.
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/ula_op_sequencer.sv
// Button-driven sequencer for the 4-bit ULA: op select, operand latch, settle wait, result capture.
module ula_op_sequencer
    import ula_op_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SETTLE_CYCLES   = 4,
    parameter int NUM_OPS         = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    input  logic [9:0] sw,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    input  logic       alu_neg,
    output logic [2:0] op_q,
    output logic [7:0] result_q,
    output logic       flag_zero_q,
    output logic       flag_err_q,
    output logic       flag_cout_q,
    output logic       busy,
    output logic       done
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic exec_evt, next_evt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_exec (
        .clk(clk), .rst_n(rst_n), .key_n(key_n[0]), .press(exec_evt)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk(clk), .rst_n(rst_n), .key_n(key_n[1]), .press(next_evt)
    );

    seq_state_t       state_q, state_d;
    logic [2:0]       op_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [7:0]       result_d;
    logic             flag_zero_d, flag_err_d, flag_cout_d;
    logic             div_zero;
    logic [7:0]       cap_val;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_sel_d   = alu_sel_q;
        settle_d    = settle_q;
        result_d    = result_q;
        flag_zero_d = flag_zero_q;
        flag_err_d  = flag_err_q;
        flag_cout_d = flag_cout_q;
        done        = 1'b0;
        div_zero    = (alu_sel_q == OP_DIV) && (alu_b_q == 4'd0);
        cap_val     = div_zero ? 8'd0 : alu_result;

        case (state_q)
            ST_IDLE: begin
                // Execute has priority; a simultaneous next-op is dropped.
                if (exec_evt) begin
                    state_d = ST_LOAD;
                end else if (next_evt) begin
                    op_d = (op_q == 3'(NUM_OPS - 1)) ? 3'd0 : op_q + 3'd1;
                end
            end
            ST_LOAD: begin
                alu_a_d   = sw[9] ? result_q[3:0] : sw[3:0];
                alu_b_d   = sw[7:4];
                alu_cin_d = sw[8];
                alu_sel_d = op_q;
                settle_d  = SET_W'(SETTLE_CYCLES - 1);
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                result_d    = cap_val;
                flag_zero_d = (cap_val == 8'd0);
                flag_err_d  = div_zero || ((alu_sel_q == OP_SUB) && alu_neg);
                flag_cout_d = (alu_sel_q == OP_SUM) && alu_cout;
                done        = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_cin_q   <= 1'b0;
            alu_sel_q   <= 3'd0;
            settle_q    <= '0;
            result_q    <= 8'd0;
            flag_zero_q <= 1'b0;
            flag_err_q  <= 1'b0;
            flag_cout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_sel_q   <= alu_sel_d;
            settle_q    <= settle_d;
            result_q    <= result_d;
            flag_zero_q <= flag_zero_d;
            flag_err_q  <= flag_err_d;
            flag_cout_q <= flag_cout_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_cin = alu_cin_q;
    assign alu_sel = alu_sel_q;

endmodule
